// File: rtl/age_ordered_scheduler_queue.sv
// Age-ordered scheduler queue between Issue and Dispatch: holds DEPTH entries and offers
// the oldest ready one each cycle, with an optional same-cycle bypass for ready arrivals.
package age_ordered_scheduler_queue_pkg;
    localparam int PHYS_REG_COUNT    = 64;
    localparam int PREG_W            = $clog2(PHYS_REG_COUNT);
    localparam int COMMIT_QUEUE_SIZE = 8;

    typedef struct packed {
        logic [3:0]        rob_tag;
        logic [7:0]        opcode;
        logic [PREG_W-1:0] dst;
        logic              uses_src1;
        logic [PREG_W-1:0] src1;
        logic              uses_src2;
        logic [PREG_W-1:0] src2;
    } instruction_t;

    typedef struct packed {
        logic [3:0]        rob_tag;
        logic [7:0]        opcode;
        logic [PREG_W-1:0] dst;
        logic              uses_src1;
        logic [PREG_W-1:0] src1;
        logic              uses_src2;
        logic [PREG_W-1:0] src2;
    } scheduler_entry_t;

    function automatic scheduler_entry_t scheduler_entry(input instruction_t ins);
        scheduler_entry_t e;
        e.rob_tag   = ins.rob_tag;
        e.opcode    = ins.opcode;
        e.dst       = ins.dst;
        e.uses_src1 = ins.uses_src1;
        e.src1      = ins.src1;
        e.uses_src2 = ins.uses_src2;
        e.src2      = ins.src2;
        return e;
    endfunction

    function automatic logic entry_ready(input scheduler_entry_t e,
                                         input logic [PHYS_REG_COUNT-1:0] reg_valid);
        return (!e.uses_src1 || reg_valid[e.src1]) && (!e.uses_src2 || reg_valid[e.src2]);
    endfunction
endpackage

module age_ordered_scheduler_queue
    import age_ordered_scheduler_queue_pkg::*;
#(
    parameter int DEPTH         = COMMIT_QUEUE_SIZE,
    parameter bit ENABLE_BYPASS = 1'b1,
    parameter int CNT_W         = $clog2(DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_flush,
    input  logic                      i_insert_enable,
    input  instruction_t              i_instruction,
    input  logic [PHYS_REG_COUNT-1:0] i_register_valid,
    input  logic                      i_take,
    output logic                      o_ready,
    output logic                      o_want_to_execute,
    output scheduler_entry_t          o_next_to_execute,
    output logic [CNT_W-1:0]          o_count,
    output logic                      o_overflow
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    scheduler_entry_t entries [DEPTH];
    logic [DEPTH-1:0] occupied;
    // older[i][j] is set when slot i holds an entry older than slot j; both must be occupied.
    logic [DEPTH-1:0] older [DEPTH];
    logic [CNT_W-1:0] count;
    logic             overflow;

    logic [DEPTH-1:0] ready_vec;
    logic [DEPTH-1:0] sel_onehot;
    logic [IDX_W-1:0] sel_idx;
    logic [IDX_W-1:0] free_idx;
    logic             any_ready;
    logic             incoming_ready;
    logic             bypass;
    logic             not_full;
    logic             do_remove;
    logic             do_insert;
    logic             do_drop;
    logic [DEPTH-1:0] occ_next;
    logic [CNT_W-1:0] count_next;

    always_comb begin
        ready_vec = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ready_vec[i] = occupied[i] && entry_ready(entries[i], i_register_valid);
        end

        // A ready slot wins only if no other ready slot is older than it.
        sel_onehot = '0;
        for (int i = 0; i < DEPTH; i++) begin
            logic blocked;
            blocked = 1'b0;
            for (int j = 0; j < DEPTH; j++) begin
                if (ready_vec[j] && older[j][i]) blocked = 1'b1;
            end
            sel_onehot[i] = ready_vec[i] && !blocked;
        end

        sel_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (sel_onehot[i]) sel_idx = IDX_W'(i);
        end

        free_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!occupied[i]) free_idx = IDX_W'(i);
        end

        any_ready      = |ready_vec;
        incoming_ready = entry_ready(scheduler_entry(i_instruction), i_register_valid);
        bypass         = ENABLE_BYPASS && !rst && !any_ready && i_insert_enable && incoming_ready;
        not_full       = (count < DEPTH_CNT);

        do_remove = !i_flush && any_ready && i_take;
        do_insert = !i_flush && i_insert_enable && !(bypass && i_take) && not_full;
        do_drop   = !i_flush && i_insert_enable && !(bypass && i_take) && !not_full;

        occ_next = occupied;
        if (do_remove) occ_next[sel_idx] = 1'b0;
        if (do_insert) occ_next[free_idx] = 1'b1;

        count_next = '0;
        for (int i = 0; i < DEPTH; i++) begin
            count_next = count_next + CNT_W'(occ_next[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occupied <= '0;
            count    <= '0;
            overflow <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                older[i]   <= '0;
                entries[i] <= '0;
            end
        end else if (i_flush) begin
            occupied <= '0;
            count    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                older[i] <= '0;
            end
        end else begin
            occupied <= occ_next;
            count    <= count_next;
            if (do_drop) overflow <= 1'b1;
            if (do_remove) begin
                for (int j = 0; j < DEPTH; j++) begin
                    older[sel_idx][j] <= 1'b0;
                    older[j][sel_idx] <= 1'b0;
                end
            end
            // The new entry is younger than every slot that stays occupied past this edge.
            if (do_insert) begin
                entries[free_idx] <= scheduler_entry(i_instruction);
                for (int j = 0; j < DEPTH; j++) begin
                    older[free_idx][j] <= 1'b0;
                    older[j][free_idx] <= occupied[j] && !(do_remove && (sel_idx == IDX_W'(j)));
                end
            end
        end
    end

    always_comb begin
        o_ready           = not_full;
        o_count           = count;
        o_overflow        = overflow;
        o_want_to_execute = any_ready || bypass;
        if (any_ready)   o_next_to_execute = entries[sel_idx];
        else if (bypass) o_next_to_execute = scheduler_entry(i_instruction);
        else             o_next_to_execute = entries[0];
    end
endmodule

// File: tb/tb_age_ordered_scheduler_queue.sv
// Directed bench for the age-ordered scheduler queue: age order, slot reuse, bypass,
// full/overflow, flush precedence and asynchronous reset.
module tb_age_ordered_scheduler_queue;
    import age_ordered_scheduler_queue_pkg::*;

    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic                      clk;
    logic                      rst;
    logic                      i_flush;
    logic                      i_insert_enable;
    instruction_t              i_instruction;
    logic [PHYS_REG_COUNT-1:0] i_register_valid;
    logic                      i_take;

    logic                      o_ready;
    logic                      o_want_to_execute;
    scheduler_entry_t          o_next_to_execute;
    logic [CNT_W-1:0]          o_count;
    logic                      o_overflow;

    logic                      nb_ready;
    logic                      nb_want_to_execute;
    scheduler_entry_t          nb_next_to_execute;
    logic [CNT_W-1:0]          nb_count;
    logic                      nb_overflow;

    int total = 0;
    int bad   = 0;
    logic [3:0] exp_q[$];

    age_ordered_scheduler_queue #(.DEPTH(DEPTH), .ENABLE_BYPASS(1'b1)) dut (
        .clk(clk), .rst(rst), .i_flush(i_flush), .i_insert_enable(i_insert_enable),
        .i_instruction(i_instruction), .i_register_valid(i_register_valid), .i_take(i_take),
        .o_ready(o_ready), .o_want_to_execute(o_want_to_execute),
        .o_next_to_execute(o_next_to_execute), .o_count(o_count), .o_overflow(o_overflow)
    );

    age_ordered_scheduler_queue #(.DEPTH(DEPTH), .ENABLE_BYPASS(1'b0)) dut_nb (
        .clk(clk), .rst(rst), .i_flush(i_flush), .i_insert_enable(i_insert_enable),
        .i_instruction(i_instruction), .i_register_valid(i_register_valid), .i_take(i_take),
        .o_ready(nb_ready), .o_want_to_execute(nb_want_to_execute),
        .o_next_to_execute(nb_next_to_execute), .o_count(nb_count), .o_overflow(nb_overflow)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic instruction_t mk(input logic [3:0] tag, input logic [5:0] src);
        instruction_t ins;
        ins           = '0;
        ins.rob_tag   = tag;
        ins.opcode    = 8'h10 + {4'h0, tag};
        ins.dst       = 6'd32 + {2'b00, tag};
        ins.uses_src1 = 1'b1;
        ins.src1      = src;
        return ins;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic insert(input logic [3:0] tag, input logic [5:0] src);
        i_insert_enable = 1'b1;
        i_instruction   = mk(tag, src);
        step();
        i_insert_enable = 1'b0;
        i_instruction   = '0;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        #1;
    endtask

    // Take entries in the order held by exp_q, checking the tag and the count after each edge.
    task automatic drain_expected(input string name);
        int remaining;
        remaining = exp_q.size();
        while (exp_q.size() > 0) begin
            logic [3:0] t;
            t = exp_q.pop_front();
            check({name, "_want"}, 64'(o_want_to_execute), 64'd1);
            check({name, "_tag"}, 64'(o_next_to_execute.rob_tag), 64'(t));
            i_take = 1'b1;
            step();
            i_take = 1'b0;
            remaining--;
            check({name, "_count"}, 64'(o_count), 64'(remaining));
        end
    endtask

    initial begin
        rst = 1'b1;
        i_flush = 1'b0;
        i_insert_enable = 1'b0;
        i_instruction = '0;
        i_register_valid = '0;
        i_take = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_count", 64'(o_count), 64'd0);
        check("rst_ready", 64'(o_ready), 64'd1);
        check("rst_want", 64'(o_want_to_execute), 64'd0);
        check("rst_next", 64'(o_next_to_execute), 64'd0);
        check("rst_ovf", 64'(o_overflow), 64'd0);
        rst = 1'b0;
        step();

        // age order: A, B, C inserted with sources invalid, then released together
        insert(4'd1, 6'd1);
        insert(4'd2, 6'd2);
        insert(4'd3, 6'd3);
        check("age_count3", 64'(o_count), 64'd3);
        check("age_idle_want", 64'(o_want_to_execute), 64'd0);
        i_register_valid = '1;
        #1;
        exp_q.push_back(4'd1);
        exp_q.push_back(4'd2);
        exp_q.push_back(4'd3);
        drain_expected("age");
        check("age_empty_want", 64'(o_want_to_execute), 64'd0);

        // slot reuse: B leaves via wakeup, D lands in slot 1 but stays youngest
        i_register_valid = '0;
        insert(4'd1, 6'd1);
        insert(4'd2, 6'd2);
        insert(4'd3, 6'd3);
        i_register_valid[2] = 1'b1;
        #1;
        check("reuse_b_tag", 64'(o_next_to_execute.rob_tag), 64'd2);
        i_take = 1'b1;
        step();
        i_take = 1'b0;
        check("reuse_count2", 64'(o_count), 64'd2);
        insert(4'd4, 6'd4);
        check("reuse_count3", 64'(o_count), 64'd3);
        i_register_valid = '1;
        #1;
        exp_q.push_back(4'd1);
        exp_q.push_back(4'd3);
        exp_q.push_back(4'd4);
        drain_expected("reuse");

        // bypass with take: nothing stored; the no-bypass instance stores it instead
        i_insert_enable = 1'b1;
        i_instruction   = mk(4'd5, 6'd9);
        i_take          = 1'b1;
        #1;
        check("byp_want", 64'(o_want_to_execute), 64'd1);
        check("byp_next", 64'(o_next_to_execute), 64'(scheduler_entry(mk(4'd5, 6'd9))));
        check("nb_byp_want", 64'(nb_want_to_execute), 64'd0);
        step();
        check("byp_take_count", 64'(o_count), 64'd0);
        check("nb_stored_count", 64'(nb_count), 64'd1);
        // bypass offered but not taken: instruction is stored
        i_take = 1'b0;
        step();
        i_insert_enable = 1'b0;
        check("byp_notake_count", 64'(o_count), 64'd1);
        pulse_reset();

        // full / overflow
        i_register_valid = '0;
        insert(4'd1, 6'd1);
        insert(4'd2, 6'd2);
        insert(4'd3, 6'd3);
        insert(4'd4, 6'd4);
        check("full_ready", 64'(o_ready), 64'd0);
        check("full_count", 64'(o_count), 64'd4);
        i_register_valid[9] = 1'b1;
        i_insert_enable = 1'b1;
        i_instruction   = mk(4'd6, 6'd9);
        i_take          = 1'b1;
        #1;
        check("full_byp_tag", 64'(o_next_to_execute.rob_tag), 64'd6);
        step();
        i_take = 1'b0;
        check("full_byp_ovf", 64'(o_overflow), 64'd0);
        check("full_byp_count", 64'(o_count), 64'd4);
        check("nb_full_drop_ovf", 64'(nb_overflow), 64'd1);
        insert(4'd7, 6'd7);
        check("ovf_set", 64'(o_overflow), 64'd1);
        check("ovf_count", 64'(o_count), 64'd4);

        // flush beats a simultaneous insert and take; overflow is held
        i_register_valid = '1;
        i_flush = 1'b1;
        i_insert_enable = 1'b1;
        i_instruction   = mk(4'd8, 6'd8);
        i_take          = 1'b1;
        step();
        i_flush = 1'b0;
        i_insert_enable = 1'b0;
        i_take = 1'b0;
        #1;
        check("flush_count", 64'(o_count), 64'd0);
        check("flush_want", 64'(o_want_to_execute), 64'd0);
        check("flush_ovf", 64'(o_overflow), 64'd1);

        // asynchronous reset mid-cycle with three entries stored
        i_register_valid = '0;
        insert(4'd1, 6'd1);
        insert(4'd2, 6'd2);
        insert(4'd3, 6'd3);
        check("pre_rst_count", 64'(o_count), 64'd3);
        rst = 1'b1;
        #1;
        check("async_rst_count", 64'(o_count), 64'd0);
        check("async_rst_ready", 64'(o_ready), 64'd1);
        check("async_rst_want", 64'(o_want_to_execute), 64'd0);
        check("async_rst_ovf", 64'(o_overflow), 64'd0);
        rst = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
